// File: rtl/address_unit.sv
// 6502 address unit: program counter, direct/indirect address registers and the
// memory address mux driven by the control unit's strobes.
module address_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic [7:0]  alu_result,
    input  logic        increment_pc,
    input  logic        branch_load,
    input  logic        indirl_load,
    input  logic        indirh_load,
    input  logic        dirl_load,
    input  logic        dirh_load,
    input  logic [2:0]  address_select,
    output logic [15:0] address,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        SEL_PC         = 3'b000,
        SEL_ZERO       = 3'b001,
        SEL_ABS        = 3'b010,
        SEL_IND_ZERO_0 = 3'b011,
        SEL_IND_ZERO_1 = 3'b100,
        SEL_IND_ABS_0  = 3'b101,
        SEL_IND_ABS_1  = 3'b110,
        SEL_SPARE      = 3'b111
    } addr_sel_e;

    logic [15:0] pc_q, pc_d;
    logic [7:0]  dirl_q, dirl_d;
    logic [7:0]  dirh_q, dirh_d;
    logic [7:0]  indirl_q, indirl_d;
    logic [7:0]  indirh_q, indirh_d;
    logic [7:0]  off_q, off_d;

    logic [7:0]  indirl_inc;
    logic [15:0] ind_abs_inc;

    always_comb begin
        dirl_d   = dirl_load   ? alu_result : dirl_q;
        dirh_d   = dirh_load   ? alu_result : dirh_q;
        indirl_d = indirl_load ? alu_result : indirl_q;
        indirh_d = indirh_load ? alu_result : indirh_q;
        // Offset latches on every fetch, even when a branch overrides the increment.
        off_d    = increment_pc ? data_in : off_q;

        pc_d = pc_q;
        if (branch_load) begin
            pc_d = pc_q + {{8{off_q[7]}}, off_q};
        end else if (increment_pc) begin
            pc_d = pc_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            dirl_q   <= '0;
            dirh_q   <= '0;
            indirl_q <= '0;
            indirh_q <= '0;
            off_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            dirl_q   <= dirl_d;
            dirh_q   <= dirh_d;
            indirl_q <= indirl_d;
            indirh_q <= indirh_d;
            off_q    <= off_d;
        end
    end

    // Zero-page pointer wraps within page zero; absolute pointer carries into the high byte.
    assign indirl_inc  = indirl_q + 8'h01;
    assign ind_abs_inc = {indirh_q, indirl_q} + 16'h0001;

    always_comb begin
        address = pc_q;
        case (address_select)
            SEL_PC:         address = pc_q;
            SEL_ZERO:       address = {8'h00, dirl_q};
            SEL_ABS:        address = {dirh_q, dirl_q};
            SEL_IND_ZERO_0: address = {8'h00, indirl_q};
            SEL_IND_ZERO_1: address = {8'h00, indirl_inc};
            SEL_IND_ABS_0:  address = {indirh_q, indirl_q};
            SEL_IND_ABS_1:  address = ind_abs_inc;
            SEL_SPARE:      address = pc_q;
            default:        address = pc_q;
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_address_unit.sv
// Directed bench for address_unit: PC sequencing, branches, register loads and the address mux.
module tb_address_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic [7:0]  alu_result;
    logic        increment_pc;
    logic        branch_load;
    logic        indirl_load;
    logic        indirh_load;
    logic        dirl_load;
    logic        dirh_load;
    logic [2:0]  address_select;
    logic [15:0] address;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    address_unit #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .alu_result     (alu_result),
        .increment_pc   (increment_pc),
        .branch_load    (branch_load),
        .indirl_load    (indirl_load),
        .indirh_load    (indirh_load),
        .dirl_load      (dirl_load),
        .dirh_load      (dirh_load),
        .address_select (address_select),
        .address        (address),
        .pc             (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        data_in        = 8'h00;
        alu_result     = 8'h00;
        increment_pc   = 1'b0;
        branch_load    = 1'b0;
        indirl_load    = 1'b0;
        indirh_load    = 1'b0;
        dirl_load      = 1'b0;
        dirh_load      = 1'b0;
        address_select = 3'b000;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    // Walk PC to target from reset: pairs of (fetch 7F, branch) add 0x80, then single increments.
    task automatic goto_pc(input logic [15:0] target);
        int unsigned m;
        do_reset();
        m = 0;
        while (int'(target) - int'(m) > 'h80) begin
            data_in = 8'h7F; increment_pc = 1'b1;
            tick();
            increment_pc = 1'b0; data_in = 8'h00; branch_load = 1'b1;
            tick();
            branch_load = 1'b0;
            m = m + 'h80;
        end
        while (m != int'(target)) begin
            increment_pc = 1'b1;
            tick();
            increment_pc = 1'b0;
            m = m + 1;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #3;
        checks++;
        if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
        checks++;
        if (address !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", address); end
        #9 rst = 1'b1;
        tick();
        checks++;
        if (address !== 16'h0000) begin errors++; $display("FAIL count0 got %h exp 0000", address); end
        increment_pc = 1'b1;
        tick();
        checks++;
        if (address !== 16'h0001 || pc !== 16'h0001) begin errors++; $display("FAIL count1 got %h/%h exp 0001", address, pc); end
        tick();
        checks++;
        if (address !== 16'h0002 || pc !== 16'h0002) begin errors++; $display("FAIL count2 got %h/%h exp 0002", address, pc); end
        tick();
        checks++;
        if (address !== 16'h0003 || pc !== 16'h0003) begin errors++; $display("FAIL count3 got %h/%h exp 0003", address, pc); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000 || address !== 16'h0000) begin errors++; $display("FAIL async_reset got %h/%h exp 0000", pc, address); end
        #1 rst = 1'b1;
        increment_pc = 1'b0;
    endtask

    task automatic test_pc_wrap_hold();
        goto_pc(16'hFFFF);
        checks++;
        if (pc !== 16'hFFFF) begin errors++; $display("FAIL pc_ffff got %h exp FFFF", pc); end
        increment_pc = 1'b1;
        tick();
        increment_pc = 1'b0;
        checks++;
        if (pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h exp 0000", pc); end
        goto_pc(16'h1234);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pc !== 16'h1234) begin errors++; $display("FAIL pc_hold%0d got %h exp 1234", i, pc); end
        end
    endtask

    task automatic test_branch();
        goto_pc(16'h0200);
        data_in = 8'hFC; increment_pc = 1'b1;
        tick();
        increment_pc = 1'b0; data_in = 8'h00;
        checks++;
        if (pc !== 16'h0201) begin errors++; $display("FAIL br_neg_fetch got %h exp 0201", pc); end
        branch_load = 1'b1;
        tick();
        branch_load = 1'b0;
        checks++;
        if (pc !== 16'h01FD) begin errors++; $display("FAIL br_neg got %h exp 01FD", pc); end

        goto_pc(16'h0200);
        data_in = 8'h7F; increment_pc = 1'b1;
        tick();
        increment_pc = 1'b0; data_in = 8'h00;
        checks++;
        if (pc !== 16'h0201) begin errors++; $display("FAIL br_pos_fetch got %h exp 0201", pc); end
        branch_load = 1'b1;
        tick();
        branch_load = 1'b0;
        checks++;
        if (pc !== 16'h0280) begin errors++; $display("FAIL br_pos got %h exp 0280", pc); end

        goto_pc(16'h02FF);
        data_in = 8'h02; increment_pc = 1'b1;
        tick();
        checks++;
        if (pc !== 16'h0300) begin errors++; $display("FAIL br_both_setup got %h exp 0300", pc); end
        data_in = 8'h55; branch_load = 1'b1;
        tick();
        increment_pc = 1'b0; data_in = 8'h00;
        checks++;
        if (pc !== 16'h0302) begin errors++; $display("FAIL br_both got %h exp 0302", pc); end
        tick();
        branch_load = 1'b0;
        checks++;
        if (pc !== 16'h0357) begin errors++; $display("FAIL br_off_capture got %h exp 0357", pc); end
    endtask

    task automatic test_dir();
        do_reset();
        dirl_load = 1'b1; alu_result = 8'h34;
        tick();
        dirl_load = 1'b0; dirh_load = 1'b1; alu_result = 8'h12;
        tick();
        dirh_load = 1'b0;
        address_select = 3'b010;
        #1;
        checks++;
        if (address !== 16'h1234) begin errors++; $display("FAIL abs got %h exp 1234", address); end
        address_select = 3'b001;
        #1;
        checks++;
        if (address !== 16'h0034) begin errors++; $display("FAIL zero got %h exp 0034", address); end
        dirl_load = 1'b1; alu_result = 8'h56;
        #1;
        checks++;
        if (address !== 16'h0034) begin errors++; $display("FAIL zero_same_cycle got %h exp 0034", address); end
        tick();
        dirl_load = 1'b0;
        checks++;
        if (address !== 16'h0056) begin errors++; $display("FAIL zero_next_cycle got %h exp 0056", address); end
    endtask

    task automatic test_indirect();
        do_reset();
        indirl_load = 1'b1; alu_result = 8'hFF;
        tick();
        indirl_load = 1'b0;
        address_select = 3'b011;
        #1;
        checks++;
        if (address !== 16'h00FF) begin errors++; $display("FAIL ind_zero0 got %h exp 00FF", address); end
        address_select = 3'b100;
        #1;
        checks++;
        if (address !== 16'h0000) begin errors++; $display("FAIL ind_zero1_wrap got %h exp 0000", address); end
        indirh_load = 1'b1; alu_result = 8'h10;
        tick();
        indirh_load = 1'b0;
        checks++;
        if (address !== 16'h0000) begin errors++; $display("FAIL ind_zero1_page got %h exp 0000", address); end
        address_select = 3'b101;
        #1;
        checks++;
        if (address !== 16'h10FF) begin errors++; $display("FAIL ind_abs0 got %h exp 10FF", address); end
        address_select = 3'b110;
        #1;
        checks++;
        if (address !== 16'h1100) begin errors++; $display("FAIL ind_abs1_carry got %h exp 1100", address); end
        indirh_load = 1'b1; alu_result = 8'hFF;
        tick();
        indirh_load = 1'b0;
        checks++;
        if (address !== 16'h0000) begin errors++; $display("FAIL ind_abs1_wrap got %h exp 0000", address); end
    endtask

    task automatic test_simultaneous_and_reset();
        do_reset();
        dirl_load = 1'b1; dirh_load = 1'b1; indirl_load = 1'b1; indirh_load = 1'b1;
        alu_result = 8'h5A;
        tick();
        dirl_load = 1'b0; dirh_load = 1'b0; indirl_load = 1'b0; indirh_load = 1'b0;
        address_select = 3'b010;
        #1;
        checks++;
        if (address !== 16'h5A5A) begin errors++; $display("FAIL multi_dir got %h exp 5A5A", address); end
        address_select = 3'b101;
        #1;
        checks++;
        if (address !== 16'h5A5A) begin errors++; $display("FAIL multi_indir got %h exp 5A5A", address); end
        rst = 1'b0;
        #1;
        checks++;
        if (address !== 16'h0000) begin errors++; $display("FAIL midop_reset got %h exp 0000", address); end
        rst = 1'b1;
        address_select = 3'b000;
    endtask

    task automatic test_sel_default();
        goto_pc(16'hABCD);
        address_select = 3'b111;
        #1;
        checks++;
        if (address !== 16'hABCD) begin errors++; $display("FAIL sel111 got %h exp ABCD", address); end
        address_select = 3'b000;
    endtask

    initial begin
        test_reset();
        test_pc_wrap_hold();
        test_branch();
        test_dir();
        test_indirect();
        test_simultaneous_and_reset();
        test_sel_default();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
